// File: rtl/tmr_scrub_regfile.sv
// Triple-redundant register file with a majority-voted read port, a background
// scrubber that repairs disagreeing words, and a fault-injection port.
module tmr_scrub_regfile #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_err,
  input  logic                 scrub_en,
  output logic                 scrub_done,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [ADDR_W-1:0]    err_addr,
  input  logic                 err_clr,
  input  logic                 inj_en,
  input  logic [1:0]           inj_copy,
  input  logic [ADDR_W-1:0]    inj_addr,
  input  logic [WIDTH-1:0]     inj_mask
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SCAN} scrubState_t;

  scrubState_t      state, stateNext;
  logic [WIDTH-1:0] memA  [DEPTH];
  logic [WIDTH-1:0] memB  [DEPTH];
  logic [WIDTH-1:0] memC  [DEPTH];
  logic [WIDTH-1:0] nextA [DEPTH];
  logic [WIDTH-1:0] nextB [DEPTH];
  logic [WIDTH-1:0] nextC [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0] ptrVote;
  logic [DEPTH-1:0] wrHit;
  logic [DEPTH-1:0] injHit;
  logic             scanActive;
  logic             ptrMismatch;
  logic             correct;

  function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Read port: zero-latency vote and disagreement flag.
  assign rd_data = vote3(memA[rd_addr], memB[rd_addr], memC[rd_addr]);
  assign rd_err  = (memA[rd_addr] != memB[rd_addr]) || (memA[rd_addr] != memC[rd_addr]);

  assign scanActive  = (state == SCAN);
  assign ptrVote     = vote3(memA[ptr], memB[ptr], memC[ptr]);
  assign ptrMismatch = (memA[ptr] != memB[ptr]) || (memA[ptr] != memC[ptr]);
  // A user write to the word under the pointer takes the place of the repair.
  assign correct     = scanActive && ptrMismatch && !(wr_en && wr_addr == ptr);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stateNext = state;
    unique case (state)
      IDLE:    if (scrub_en)  stateNext = SCAN;
      SCAN:    if (!scrub_en) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    wrHit  = '0;
    injHit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wrHit[i]  = wr_en && (wr_addr == ADDR_W'(i));
      injHit[i] = inj_en && (inj_addr == ADDR_W'(i)) && !wrHit[i];
    end
  end

  // Per word: user write beats correction; injection lands on top of the result.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nextA[i] = memA[i];
      nextB[i] = memB[i];
      nextC[i] = memC[i];
      if (wrHit[i]) begin
        nextA[i] = wr_data;
        nextB[i] = wr_data;
        nextC[i] = wr_data;
      end else if (correct && ptr == ADDR_W'(i)) begin
        nextA[i] = ptrVote;
        nextB[i] = ptrVote;
        nextC[i] = ptrVote;
      end
      if (injHit[i]) begin
        case (inj_copy)
          2'd0:    nextA[i] = nextA[i] ^ inj_mask;
          2'd1:    nextB[i] = nextB[i] ^ inj_mask;
          2'd2:    nextC[i] = nextC[i] ^ inj_mask;
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      scrub_done <= 1'b0;
      err_count  <= '0;
      err_addr   <= '0;
      // NOTE: the storage itself is cleared on reset because every copy must
      // start equal; otherwise the vote and scrubber would act on garbage.
      for (int i = 0; i < DEPTH; i++) begin
        memA[i] <= '0;
        memB[i] <= '0;
        memC[i] <= '0;
      end
    end else begin
      state      <= stateNext;
      scrub_done <= scanActive && (ptr == LastAddr);
      for (int i = 0; i < DEPTH; i++) begin
        memA[i] <= nextA[i];
        memB[i] <= nextB[i];
        memC[i] <= nextC[i];
      end
      if (scanActive) ptr <= (ptr == LastAddr) ? '0 : ptr + ADDR_W'(1);
      if (correct)    err_addr <= ptr;
      if (err_clr)
        err_count <= CNT_WIDTH'(correct);
      else if (correct && err_count != '1)
        err_count <= err_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Bench for tmr_scrub_regfile: directed scenarios plus random traffic, all checked
// against an array-based model of the three copies.
module tb_tmr_scrub_regfile;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 8;
  localparam int CWS   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, wr_en = 1'b0, scrub_en = 1'b0, err_clr = 1'b0, inj_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0, rd_addr = '0, inj_addr = '0;
  logic [WIDTH-1:0] wr_data = '0, inj_mask = '0;
  logic [1:0]       inj_copy = 2'd3;

  logic [WIDTH-1:0] rd_data, rdDataS;
  logic             rd_err, rdErrS, scrub_done, doneS;
  logic [CW-1:0]    err_count;
  logic [CWS-1:0]   cntS;
  logic [AW-1:0]    err_addr, addrS;

  tmr_scrub_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err), .scrub_en(scrub_en),
    .scrub_done(scrub_done), .err_count(err_count), .err_addr(err_addr),
    .err_clr(err_clr), .inj_en(inj_en), .inj_copy(inj_copy), .inj_addr(inj_addr),
    .inj_mask(inj_mask));

  tmr_scrub_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CWS)) dutSat (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdDataS), .rd_err(rdErrS), .scrub_en(scrub_en),
    .scrub_done(doneS), .err_count(cntS), .err_addr(addrS),
    .err_clr(err_clr), .inj_en(inj_en), .inj_copy(inj_copy), .inj_addr(inj_addr),
    .inj_mask(inj_mask));

  int tests = 0;
  int fails = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: three plain arrays of words, scan pointer and counters.
  logic [WIDTH-1:0] mCopy [3][DEPTH];
  int mPtr = 0, mCnt = 0, mCntS = 0, mErrAddr = 0;
  bit mScan = 0, mDone = 0;

  function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always @(posedge clk) begin : model_step
    logic corr;
    logic [WIDTH-1:0] v;
    int p;
    if (rst) begin
      for (int c = 0; c < 3; c++)
        for (int a = 0; a < DEPTH; a++) mCopy[c][a] = '0;
      mPtr = 0; mScan = 0; mDone = 0; mCnt = 0; mCntS = 0; mErrAddr = 0;
    end else begin
      p = mPtr;
      v = vote3(mCopy[0][p], mCopy[1][p], mCopy[2][p]);
      corr = mScan && !(mCopy[0][p] == mCopy[1][p] && mCopy[1][p] == mCopy[2][p])
             && !(wr_en && int'(wr_addr) == p);
      if (corr) for (int c = 0; c < 3; c++) mCopy[c][p] = v;
      if (wr_en) for (int c = 0; c < 3; c++) mCopy[c][int'(wr_addr)] = wr_data;
      if (inj_en && inj_copy != 2'd3 && !(wr_en && wr_addr == inj_addr))
        mCopy[int'(inj_copy)][int'(inj_addr)] ^= inj_mask;
      if (err_clr) begin
        mCnt  = int'(corr);
        mCntS = int'(corr);
      end else if (corr) begin
        if (mCnt < (1 << CW) - 1)   mCnt++;
        if (mCntS < (1 << CWS) - 1) mCntS++;
      end
      if (corr) mErrAddr = p;
      mDone = mScan && (p == DEPTH - 1);
      if (mScan) mPtr = (p + 1) % DEPTH;
      mScan = scrub_en;
    end
  end

  // Compare process: every output of both instances, every cycle after reset.
  always @(negedge clk) begin
    logic [WIDTH-1:0] expRd;
    logic expErr;
    if (started) begin
      expRd  = vote3(mCopy[0][rd_addr], mCopy[1][rd_addr], mCopy[2][rd_addr]);
      expErr = (mCopy[0][rd_addr] != mCopy[1][rd_addr]) || (mCopy[0][rd_addr] != mCopy[2][rd_addr]);
      check("cmp_rd_data",   32'(rd_data),    32'(expRd));
      check("cmp_rd_err",    32'(rd_err),     32'(expErr));
      check("cmp_done",      32'(scrub_done), 32'(mDone));
      check("cmp_err_count", 32'(err_count),  32'(mCnt));
      check("cmp_err_addr",  32'(err_addr),   32'(mErrAddr));
      check("cmp_sat_rd",    32'(rdDataS),    32'(expRd));
      check("cmp_sat_err",   32'(rdErrS),     32'(expErr));
      check("cmp_sat_done",  32'(doneS),      32'(mDone));
      check("cmp_sat_count", 32'(cntS),       32'(mCntS));
      check("cmp_sat_addr",  32'(addrS),      32'(mErrAddr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0; inj_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic inject(input int copy, input int addr, input logic [WIDTH-1:0] mask);
    inj_en = 1'b1; inj_copy = 2'(copy); inj_addr = AW'(addr); inj_mask = mask;
    step();
  endtask

  task automatic write(input int addr, input logic [WIDTH-1:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    step();
  endtask

  task automatic wait_ptr(input int target);
    for (int k = 0; k < 3 * DEPTH && mPtr != target; k++) step();
    check("wait_ptr_timeout", 32'(mPtr), 32'(target));
  endtask

  task automatic read_check(input string name, input int addr,
                            input logic [WIDTH-1:0] expData, input logic expErr);
    rd_addr = AW'(addr);
    #1;
    check({name, "_data"}, 32'(rd_data), 32'(expData));
    check({name, "_err"},  32'(rd_err),  32'(expErr));
  endtask

  initial begin
    int p, pulses;
    rst = 1'b1;
    step();
    started = 1;
    step();
    rst = 1'b0;

    // 1: reset contents, then a write visible next cycle
    for (int a = 0; a < DEPTH; a++) read_check("reset_rd", a, 8'h00, 1'b0);
    check("reset_count", 32'(err_count), 32'd0);
    write(2, 8'hA5);
    read_check("wr_a5", 2, 8'hA5, 1'b0);
    read_check("wr_other", 0, 8'h00, 1'b0);

    // 2: single-copy fault masked by the vote, then scrubbed
    inject(1, 2, 8'h0F);
    read_check("inj_b", 2, 8'hA5, 1'b1);
    scrub_en = 1'b1;
    repeat (DEPTH + 2) step();
    read_check("scrubbed", 2, 8'hA5, 1'b0);
    check("scrub_count", 32'(err_count), 32'd1);
    check("scrub_addr",  32'(err_addr),  32'd2);

    // 3: double fault on one bit, scrubber writes back the wrong vote
    err_clr = 1'b1;
    step();
    check("clr_count", 32'(err_count), 32'd0);
    wait_ptr(2);
    inject(0, 1, 8'h01);
    inject(2, 1, 8'h01);
    read_check("double", 1, 8'h01, 1'b1);
    step();
    step();
    read_check("double_fix", 1, 8'h01, 1'b0);
    check("double_count", 32'(err_count), 32'd1);
    check("double_addr",  32'(err_addr),  32'd1);

    // 4: user write on the scrub address suppresses the correction
    wait_ptr(0);
    inject(0, 3, 8'hFF);
    read_check("pre_wr3", 3, 8'h00, 1'b1);
    wait_ptr(3);
    write(3, 8'h3C);
    read_check("wr3", 3, 8'h3C, 1'b0);
    check("wr3_count", 32'(err_count), 32'd1);
    check("wr3_done",  32'(scrub_done), 32'd1);

    // 5: saturation on the narrow counter, and clear coinciding with a correction
    err_clr = 1'b1;
    step();
    check("sat_clr", 32'(cntS), 32'd0);
    for (int n = 0; n < 5; n++) begin
      p = mPtr;
      inject(1, (p + 2) % DEPTH, 8'h80);
      step();
      step();
    end
    check("five_count", 32'(err_count), 32'd5);
    check("five_sat",   32'(cntS),      32'd3);
    p = mPtr;
    inject(1, (p + 1) % DEPTH, 8'h40);
    err_clr = 1'b1;
    step();
    check("clr_corr_count", 32'(err_count), 32'd1);
    check("clr_corr_sat",   32'(cntS),      32'd1);
    check("clr_corr_addr",  32'(err_addr),  32'((p + 1) % DEPTH));

    // 6: scrub_done cadence, then reset mid-scan
    pulses = 0;
    repeat (4 * DEPTH) begin
      step();
      if (scrub_done) pulses++;
    end
    check("done_pulses", 32'(pulses), 32'd4);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_count", 32'(err_count),  32'd0);
    check("rst_sat",   32'(cntS),       32'd0);
    check("rst_addr",  32'(err_addr),   32'd0);
    check("rst_done",  32'(scrub_done), 32'd0);
    for (int a = 0; a < DEPTH; a++) read_check("rst_rd", a, 8'h00, 1'b0);
    rst = 1'b0;
    repeat (DEPTH) step();
    check("restart_quiet", 32'(scrub_done), 32'd0);
    step();
    check("restart_done",  32'(scrub_done), 32'd1);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rst      = ($urandom_range(0, 149) == 0);
      scrub_en = ($urandom_range(0, 7) != 0);
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = WIDTH'($urandom);
      inj_en   = ($urandom_range(0, 3) == 0);
      inj_copy = 2'($urandom_range(0, 3));
      inj_addr = AW'($urandom_range(0, DEPTH - 1));
      inj_mask = WIDTH'($urandom);
      err_clr  = ($urandom_range(0, 31) == 0);
      rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_regfile.md
Name: tmr_scrub_regfile

Overview:
- Parametrised successor to the single-bit self-refreshing TMR flip-flop.
- Holds DEPTH words of WIDTH bits in three redundant copies (A/B/C).
- Exposes a bitwise majority-voted read port.
- A background scrubber walks all addresses, rewrites any word whose copies disagree, and keeps a saturating error counter. A fault-injection port exists for verification and radiation-test setups.

Parameters:
WIDTH, 8, data bits per word
DEPTH, 4, number of words (≥2); ADDR_W = clog2(DEPTH)
CNT_WIDTH, 8, width of corrected-error counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  user write strobe
wr_addr  in  ADDR_W  user write address
wr_data  in  WIDTH  user write data
rd_addr  in  ADDR_W  read address
rd_data  out  WIDTH  bitwise majority of A/B/C at rd_addr (combinational)
rd_err  out  1  high when any copy at rd_addr differs from the others (combinational)
scrub_en  in  1  enable background scrubbing
scrub_done  out  1  one-cycle pulse when the scrubber finishes address DEPTH-1
err_count  out  CNT_WIDTH  number of scrub corrections, saturating
err_addr  out  ADDR_W  address of the most recent scrub correction
err_clr  in  1  clears err_count to 0
inj_en  in  1  fault-injection strobe
inj_copy  in  2  copy to corrupt: 0=A, 1=B, 2=C, 3=none
inj_addr  in  ADDR_W  injection address
inj_mask  in  WIDTH  bits XORed into the selected copy

Behaviour:
- Reset (rst=1 at an edge):
  - All three copies of every word → 0.
  - Scrub pointer → 0.
  - err_count → 0, err_addr → 0, scrub_done → 0.
  - rst overrides every other input.
- Voting: vote[b] = A[b]&B[b] | A[b]&C[b] | B[b]&C[b], per bit. Mismatch on a word = (A!=B) | (A!=C).
- User write: wr_en=1 loads wr_data into all three copies at wr_addr. It is visible on rd_data in the next cycle.
- Read: rd_data and rd_err are purely combinational, with zero latency from rd_addr or from storage changes.
- Scrubber FSM has two states:
  - IDLE: entered from reset or when scrub_en=0. The pointer holds its value.
  - SCAN: entered when scrub_en=1. Each cycle the word at the pointer is evaluated.
    - If it mismatches, all three copies are written with the voted value, err_addr ← pointer, and err_count increments.
    - The pointer then advances, wrapping DEPTH-1 → 0.
    - scrub_done=1 in the cycle after the pointer leaves DEPTH-1.
  - Dropping scrub_en returns the FSM to IDLE without resetting the pointer. Scanning resumes at the same address.
- err_count saturates at 2^CNT_WIDTH-1. err_clr=1 sets it to 0. If err_clr and a correction occur in the same cycle, the result is 1.
- Same-cycle priority per storage word/copy:
  - next = (user write ? wr_data : scrub correction ? vote : current) ^ (inj mask if inj targets this copy/address and no user write).
  - A user write to the scrub address suppresses the correction. err_count and err_addr are then unchanged, and the pointer still advances.
  - Injection is ignored on a word being user-written.
  - Injection on a word being corrected applies to the corrected value.
  - inj_copy=3 has no effect.
- A double fault (two copies wrong on the same bit) is not detectable as uncorrectable. The scrubber writes back the voted, wrong value and counts one correction.
- Reset asserted mid-scan: reset wins immediately. No correction or count occurs in that cycle.

Test Plan:
1. Reset, then write 0xA5 to addr 2 → next cycle rd_addr=2 gives rd_data=0xA5, rd_err=0. All other addresses read 0.
2. Holding scrub_en=0, inject mask 0x0F into copy B at addr 2 → rd_data=0xA5 and rd_err=1. Enable scrub → within DEPTH cycles rd_err=0, err_count=1, err_addr=2.
3. With scrub_en=1, inject 0x01 into copy A and 0x01 into copy C at addr 1 (data 0x00) → rd_data=0x01. The scrubber rewrites 0x01 to all copies, err_count=1, rd_err=0.
4. Inject a fault at addr 3, then user-write 0x3C to addr 3 in the cycle the scrubber reaches addr 3 → word=0x3C in all copies, err_count unchanged, pointer at 0 next cycle.
5. With CNT_WIDTH=2, cause 5 corrections → err_count stays 3. Assert err_clr together with a correction → err_count=1.
6. With scrub_en=1 and no faults → scrub_done pulses every DEPTH cycles. Assert rst mid-scan → pointer=0, all outputs 0, storage cleared.
